// File: rtl/controlador_botoes_n.sv
// Button controller for N independent channels.
// Each channel has a 2-flop synchronizer, a debounce FSM, hold detection and
// auto-repeat. A combo pulse fires when every channel becomes pressed together.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// SOLTO       | released and debounced; waiting for a press
// DEB_PRESS   | press seen; counting stable cycles before accepting it
// PRESSIONADO | press accepted; counting toward a hold
// SEGURADO    | hold declared; emitting repeat pulses every repeat period
// DEB_SOLTA   | release seen; counting stable cycles before accepting it
module controlador_botoes_n #(
  parameter int N_BOTOES        = 2,
  parameter int DEBOUNCE_CICLOS = 250000,
  parameter int HOLD_CICLOS     = 12000000,
  parameter int REPEAT_CICLOS   = 3000000,
  parameter bit ATIVO_BAIXO     = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_BOTOES-1:0] b_in,
  output logic [N_BOTOES-1:0] b_out,
  output logic [N_BOTOES-1:0] b_hold_out,
  output logic [N_BOTOES-1:0] b_repeat_out,
  output logic [N_BOTOES-1:0] b_nivel,
  output logic                b_combo
);

  localparam int MAIOR_DH = (DEBOUNCE_CICLOS > HOLD_CICLOS) ? DEBOUNCE_CICLOS : HOLD_CICLOS;
  localparam int MAIOR    = (MAIOR_DH > REPEAT_CICLOS) ? MAIOR_DH : REPEAT_CICLOS;
  localparam int CW       = $clog2(MAIOR) + 1;

  localparam logic [CW-1:0] DEB_FIM  = CW'(DEBOUNCE_CICLOS - 1);
  localparam logic [CW-1:0] HOLD_FIM = CW'(HOLD_CICLOS - 1);
  localparam logic [CW-1:0] REP_FIM  = (REPEAT_CICLOS > 0) ? CW'(REPEAT_CICLOS - 1) : '0;

  // Synchronizers reset to the idle pin level so a reset never looks like a press.
  localparam logic [N_BOTOES-1:0] REPOUSO = {N_BOTOES{ATIVO_BAIXO}};

  typedef enum logic [2:0] {
    SOLTO,
    DEB_PRESS,
    PRESSIONADO,
    SEGURADO,
    DEB_SOLTA
  } estado_t;

  logic [N_BOTOES-1:0] sync_a, sync_b, pressionado;
  logic [N_BOTOES-1:0] nivel_prox;

  // Two-flop synchronizer on every raw pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a <= REPOUSO;
      sync_b <= REPOUSO;
    end else begin
      sync_a <= b_in;
      sync_b <= sync_a;
    end
  end

  assign pressionado = sync_b ^ REPOUSO;

  for (genvar i = 0; i < N_BOTOES; i++) begin : g_canal
    estado_t       estado, estado_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          curto, curto_nxt;
    logic          nivel, nivel_nxt;
    logic          p_curto, p_curto_nxt;
    logic          p_hold, p_hold_nxt;
    logic          p_rep, p_rep_nxt;

    // Channel state, counter and registered pulse outputs.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        estado  <= SOLTO;
        cnt     <= '0;
        curto   <= 1'b0;
        nivel   <= 1'b0;
        p_curto <= 1'b0;
        p_hold  <= 1'b0;
        p_rep   <= 1'b0;
      end else begin
        estado  <= estado_nxt;
        cnt     <= cnt_nxt;
        curto   <= curto_nxt;
        nivel   <= nivel_nxt;
        p_curto <= p_curto_nxt;
        p_hold  <= p_hold_nxt;
        p_rep   <= p_rep_nxt;
      end
    end

    // Next-state, counter and pulse decisions for one channel.
    always_comb begin
      estado_nxt  = estado;
      cnt_nxt     = cnt;
      curto_nxt   = curto;
      nivel_nxt   = nivel;
      p_curto_nxt = 1'b0;
      p_hold_nxt  = 1'b0;
      p_rep_nxt   = 1'b0;
      case (estado)
        SOLTO: begin
          if (pressionado[i]) begin
            estado_nxt = DEB_PRESS;
            cnt_nxt    = '0;
          end
        end
        DEB_PRESS: begin
          if (!pressionado[i]) begin
            estado_nxt = SOLTO;
          end else if (cnt == DEB_FIM) begin
            estado_nxt = PRESSIONADO;
            nivel_nxt  = 1'b1;
            cnt_nxt    = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        PRESSIONADO: begin
          if (!pressionado[i]) begin
            estado_nxt = DEB_SOLTA;
            curto_nxt  = 1'b1;
            cnt_nxt    = '0;
          end else if (cnt == HOLD_FIM) begin
            estado_nxt = SEGURADO;
            p_hold_nxt = 1'b1;
            cnt_nxt    = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        SEGURADO: begin
          if (!pressionado[i]) begin
            estado_nxt = DEB_SOLTA;
            curto_nxt  = 1'b0;
            cnt_nxt    = '0;
          end else if (REPEAT_CICLOS > 0) begin
            if (cnt == REP_FIM) begin
              p_rep_nxt = 1'b1;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt + CW'(1);
            end
          end
        end
        DEB_SOLTA: begin
          // A bounce sends us back to where the release started, timer restarted.
          if (pressionado[i]) begin
            estado_nxt = curto ? PRESSIONADO : SEGURADO;
            cnt_nxt    = '0;
          end else if (cnt == DEB_FIM) begin
            estado_nxt  = SOLTO;
            nivel_nxt   = 1'b0;
            p_curto_nxt = curto;
            cnt_nxt     = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        default: begin
          estado_nxt = SOLTO;
          cnt_nxt    = '0;
        end
      endcase
    end

    assign nivel_prox[i]   = nivel_nxt;
    assign b_nivel[i]      = nivel;
    assign b_out[i]        = p_curto;
    assign b_hold_out[i]   = p_hold;
    assign b_repeat_out[i] = p_rep;
  end

  // Combo fires in the same cycle the registered levels become all-pressed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_combo <= 1'b0;
    end else begin
      b_combo <= (&nivel_prox) & ~(&b_nivel);
    end
  end

endmodule

// File: tb/tb_controlador_botoes_n.sv
// Bench for controlador_botoes_n: directed scenarios followed by random button
// activity, all checked every cycle against a run-length reference model.
module tb_controlador_botoes_n;

  localparam int N = 2;
  localparam int D = 4;
  localparam int H = 10;
  localparam int R = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] b_in = '1;
  logic [N-1:0] b_out, b_hold_out, b_repeat_out, b_nivel;
  logic         b_combo;

  controlador_botoes_n #(
    .N_BOTOES(N), .DEBOUNCE_CICLOS(D), .HOLD_CICLOS(H),
    .REPEAT_CICLOS(R), .ATIVO_BAIXO(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .b_in(b_in), .b_out(b_out),
    .b_hold_out(b_hold_out), .b_repeat_out(b_repeat_out),
    .b_nivel(b_nivel), .b_combo(b_combo)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: pin pipeline plus per-channel run lengths.
  logic [N-1:0] m_s1, m_s2, m_lvl;
  logic [N-1:0] m_held;
  int           m_opp[N];
  int           m_t[N];
  logic [N-1:0] e_out, e_hold, e_rep, e_lvl;
  logic         e_combo;

  // Observed-event bookkeeping relative to the last mark().
  int edge_no;
  int rise_edge[N], hold_edge[N], rep_first[N], cnt_out[N], cnt_hold[N], cnt_rep[N];
  int cnt_combo, combo_edge;

  task automatic model_reset();
    m_s1 = '1; m_s2 = '1; m_lvl = '0; m_held = '0;
    for (int c = 0; c < N; c++) begin m_opp[c] = 0; m_t[c] = 0; end
    e_out = '0; e_hold = '0; e_rep = '0; e_lvl = '0; e_combo = 1'b0;
  endtask

  task automatic model_edge();
    logic [N-1:0] p;
    logic         all_before;
    p = ~m_s2;
    m_s2 = m_s1;
    m_s1 = b_in;
    all_before = &m_lvl;
    e_out = '0; e_hold = '0; e_rep = '0;
    for (int c = 0; c < N; c++) begin
      if (!m_lvl[c]) begin
        if (p[c]) m_opp[c]++; else m_opp[c] = 0;
        if (m_opp[c] == D + 1) begin
          m_lvl[c] = 1'b1; m_held[c] = 1'b0; m_t[c] = 0; m_opp[c] = 0;
        end
      end else if (!p[c]) begin
        m_opp[c]++;
        if (m_opp[c] == D + 1) begin
          m_lvl[c] = 1'b0; m_opp[c] = 0;
          if (!m_held[c]) e_out[c] = 1'b1;
        end
      end else if (m_opp[c] > 0) begin
        m_opp[c] = 0; m_t[c] = 0;
      end else begin
        m_t[c]++;
        if (!m_held[c] && m_t[c] == H) begin
          m_held[c] = 1'b1; e_hold[c] = 1'b1; m_t[c] = 0;
        end else if (m_held[c] && R > 0 && m_t[c] == R) begin
          e_rep[c] = 1'b1; m_t[c] = 0;
        end
      end
    end
    e_lvl = m_lvl;
    e_combo = (&m_lvl) & ~all_before;
  endtask

  task automatic check(input string tag);
    n_cmp++;
    assert (b_out === e_out) else begin
      n_err++; $error("FAIL %s.b_out observed=%b expected=%b", tag, b_out, e_out);
    end
    n_cmp++;
    assert (b_hold_out === e_hold) else begin
      n_err++; $error("FAIL %s.b_hold_out observed=%b expected=%b", tag, b_hold_out, e_hold);
    end
    n_cmp++;
    assert (b_repeat_out === e_rep) else begin
      n_err++; $error("FAIL %s.b_repeat_out observed=%b expected=%b", tag, b_repeat_out, e_rep);
    end
    n_cmp++;
    assert (b_nivel === e_lvl) else begin
      n_err++; $error("FAIL %s.b_nivel observed=%b expected=%b", tag, b_nivel, e_lvl);
    end
    n_cmp++;
    assert (b_combo === e_combo) else begin
      n_err++; $error("FAIL %s.b_combo observed=%b expected=%b", tag, b_combo, e_combo);
    end
  endtask

  task automatic chk_int(input string tag, input int got, input int exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++; $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic mark();
    edge_no = 0; cnt_combo = 0; combo_edge = -1;
    for (int c = 0; c < N; c++) begin
      rise_edge[c] = -1; hold_edge[c] = -1; rep_first[c] = -1;
      cnt_out[c] = 0; cnt_hold[c] = 0; cnt_rep[c] = 0;
    end
  endtask

  task automatic tally();
    for (int c = 0; c < N; c++) begin
      if (b_nivel[c] && rise_edge[c] < 0) rise_edge[c] = edge_no;
      if (b_out[c]) cnt_out[c]++;
      if (b_hold_out[c]) begin cnt_hold[c]++; if (hold_edge[c] < 0) hold_edge[c] = edge_no; end
      if (b_repeat_out[c]) begin cnt_rep[c]++; if (rep_first[c] < 0) rep_first[c] = edge_no; end
    end
    if (b_combo) begin cnt_combo++; if (combo_edge < 0) combo_edge = edge_no; end
  endtask

  task automatic step(input int n, input string tag);
    repeat (n) begin
      @(posedge clk);
      if (!rst_n) model_reset(); else model_edge();
      #1;
      edge_no++;
      check(tag);
      tally();
    end
  endtask

  task automatic async_reset(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    check(tag);
  endtask

  int seg_left[N];

  initial begin
    model_reset();
    mark();
    repeat (2) @(posedge clk);
    #1;
    check("reset");
    rst_n = 1'b1;
    step(4, "idle");

    // Short press: 8 cycles low, then released.
    mark();
    b_in[0] = 1'b0;
    step(8, "short_press");
    b_in[0] = 1'b1;
    step(12, "short_release");
    chk_int("short.rise_edge", rise_edge[0], 7);
    chk_int("short.b_out_count", cnt_out[0], 1);
    chk_int("short.b_out_edge", rise_edge[0] + 8, 15);
    chk_int("short.hold_count", cnt_hold[0], 0);

    // Bouncing input never gets accepted.
    mark();
    for (int k = 0; k < 30; k++) begin
      b_in[0] = (k % 3 == 0) ? 1'b0 : 1'b1;
      step(1, "glitch");
    end
    b_in[0] = 1'b1;
    step(6, "glitch_end");
    chk_int("glitch.rise_edge", rise_edge[0], -1);
    chk_int("glitch.b_out_count", cnt_out[0], 0);

    // Long hold on channel 1 with auto-repeat.
    mark();
    b_in[1] = 1'b0;
    step(30, "hold");
    b_in[1] = 1'b1;
    step(10, "hold_release");
    chk_int("hold.rise_edge", rise_edge[1], 7);
    chk_int("hold.hold_edge", hold_edge[1], 17);
    chk_int("hold.hold_count", cnt_hold[1], 1);
    chk_int("hold.first_repeat", rep_first[1], 20);
    chk_int("hold.repeat_count", cnt_rep[1], 5);
    chk_int("hold.b_out_count", cnt_out[1], 0);

    // Combo: ch0 then ch1 while ch0 is held.
    mark();
    b_in[0] = 1'b0;
    step(10, "combo_a");
    b_in[1] = 1'b0;
    step(12, "combo_b");
    chk_int("combo.edge", combo_edge, 17);
    b_in = '1;
    step(12, "combo_release");
    chk_int("combo.count", cnt_combo, 1);

    // Reset mid-debounce, then mid-hold, with the button still pressed.
    mark();
    b_in = 2'b10;
    step(4, "rst_deb_pre");
    async_reset("rst_mid_debounce");
    step(2, "rst_deb_held");
    rst_n = 1'b1;
    mark();
    step(20, "rst_deb_after");
    chk_int("rst_deb.rise_edge", rise_edge[0], 7);
    chk_int("rst_deb.hold_edge", hold_edge[0], 17);
    async_reset("rst_mid_hold");
    step(2, "rst_hold_held");
    rst_n = 1'b1;
    mark();
    step(9, "rst_hold_after");
    chk_int("rst_hold.rise_edge", rise_edge[0], 7);
    b_in = '1;
    step(10, "rst_release");

    // Random button activity with occasional resets.
    for (int c = 0; c < N; c++) seg_left[c] = 0;
    for (int k = 0; k < 1500; k++) begin
      for (int c = 0; c < N; c++) begin
        if (seg_left[c] == 0) begin
          b_in[c] = 1'($urandom_range(0, 1));
          seg_left[c] = int'($urandom_range(1, 20));
        end
        seg_left[c]--;
      end
      if ($urandom_range(0, 199) == 0) async_reset("rnd_reset");
      step(1, "random");
      rst_n = 1'b1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/controlador_botoes_n.md
CONTROLADOR_BOTOES_N -- requirements
Module: controlador_botoes_n

Interface
REQ-001 SHALL have parameter N_BOTOES, default 2: number of independent button channels (1..8).
REQ-002 SHALL have parameter DEBOUNCE_CICLOS, default 250000: stable cycles required to accept a press or release (>=1).
REQ-003 SHALL have parameter HOLD_CICLOS, default 12000000: accepted-press cycles before a hold is declared (>DEBOUNCE_CICLOS).
REQ-004 SHALL have parameter REPEAT_CICLOS, default 3000000: auto-repeat period while held; 0 disables repeat.
REQ-005 SHALL have parameter ATIVO_BAIXO, default 1: 1 means raw input low = pressed.
REQ-006 SHALL have port clk  input  1  single system clock, all logic on its rising edge.
REQ-007 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port b_in  input  N_BOTOES  raw asynchronous button pins.
REQ-009 SHALL have port b_out  output  N_BOTOES  one-cycle short-press pulse per channel.
REQ-010 SHALL have port b_hold_out  output  N_BOTOES  one-cycle pulse when a hold is declared.
REQ-011 SHALL have port b_repeat_out  output  N_BOTOES  one-cycle pulse per repeat period while held.
REQ-012 SHALL have port b_nivel  output  N_BOTOES  debounced pressed level.
REQ-013 SHALL have port b_combo  output  1  one-cycle pulse when all channels become simultaneously pressed.

Function
REQ-014 Each channel SHALL pass b_in through a 2-flop synchronizer, then normalise polarity per ATIVO_BAIXO.
REQ-015 Each channel SHALL run an independent FSM: SOLTO, DEB_PRESS, PRESSIONADO, SEGURADO, DEB_SOLTA, with one counter sized $clog2 of the largest parameter plus 1.
REQ-016 SOLTO: pressed -> DEB_PRESS, counter = 0; otherwise remain.
REQ-017 DEB_PRESS: released -> SOLTO with no output; counter == DEBOUNCE_CICLOS-1 -> PRESSIONADO, b_nivel = 1, counter = 0.
REQ-018 PRESSIONADO: released -> DEB_SOLTA with origin flag curto = 1; counter == HOLD_CICLOS-1 -> SEGURADO, b_hold_out pulse, counter = 0.
REQ-019 SEGURADO: released -> DEB_SOLTA with curto = 0; if REPEAT_CICLOS > 0, pulse b_repeat_out each time counter == REPEAT_CICLOS-1 and wrap counter to 0.
REQ-020 DEB_SOLTA: pressed before counter == DEBOUNCE_CICLOS-1 -> return to origin state (PRESSIONADO or SEGURADO) with counter = 0; completion -> SOLTO, b_nivel = 0, b_out pulse only if curto = 1.
REQ-021 A hold-ended release SHALL NOT produce b_out; a bounce-rejected press SHALL produce no output at all.
REQ-022 Latency: a press held stably from cycle 0 SHALL raise b_nivel at edge DEBOUNCE_CICLOS+3; b_hold_out SHALL follow HOLD_CICLOS cycles after b_nivel rises.
REQ-023 All pulse outputs SHALL be registered and exactly one cycle wide; counters SHALL never wrap outside the stated compare points.
REQ-024 b_combo SHALL pulse in the single cycle in which the AND of all b_nivel bits transitions 0 -> 1; with N_BOTOES = 1 it SHALL mirror the b_nivel rising edge.
REQ-025 Channels SHALL not interact; simultaneous events on different channels SHALL each produce their own pulses in the same cycle.

Reset
REQ-026 rst_n low SHALL immediately clear synchronizers and counters, force all FSMs to SOLTO and drive b_out, b_hold_out, b_repeat_out, b_nivel and b_combo to 0.
REQ-027 Reset asserted mid-press SHALL discard the press; after release of reset a still-pressed button SHALL restart from DEB_PRESS with full debounce.

Verification (DEBOUNCE_CICLOS=4, HOLD_CICLOS=10, REPEAT_CICLOS=3, N_BOTOES=2, ATIVO_BAIXO=1)
REQ-028 Drive b_in[0] low for 8 cycles then high -> b_nivel[0] rises at edge 7, one b_out[0] pulse after 4 stable-high cycles, no hold.
REQ-029 Drive b_in[0] low with 2-cycle glitches every 3 cycles -> b_nivel[0], b_out[0] remain 0.
REQ-030 Hold b_in[1] low for 30 cycles -> b_hold_out[1] pulse 10 cycles after b_nivel[1], then b_repeat_out[1] every 3 cycles, no b_out[1] on release.
REQ-031 Press ch0, then ch1 while ch0 held -> single b_combo pulse when b_nivel becomes 2'b11; none on release.
REQ-032 Assert rst_n low mid-debounce and mid-hold -> all outputs 0 same cycle; with button still pressed, b_nivel rises 7 edges after reset release.
